// File: rtl/digger_pkg.sv
// Purpose: shared constants and diamond placement table for the diamond block.
// Latency: n/a (constants only).
// Backpressure: n/a.
package digger_pkg;

    localparam int          DIAMOND_SIZE = 32;
    localparam int          MAX_DIAMONDS = 8;
    localparam logic [11:0] TRANSPARENT  = 12'hFFF;

    // Sparkle phase: the last quarter of the 64-frame cycle tints the green channel.
    localparam logic [5:0]  SPARKLE_START = 6'd48;
    localparam logic [11:0] SPARKLE_MASK  = 12'h0F0;

    // Board-relative top-left corner of each diamond cell.
    localparam logic [10:0] DIAMOND_POS_X [MAX_DIAMONDS] = '{
        11'd0, 11'd64, 11'd128, 11'd192, 11'd256, 11'd320, 11'd384, 11'd448
    };
    localparam logic [10:0] DIAMOND_POS_Y [MAX_DIAMONDS] = '{
        11'd0, 11'd64, 11'd0, 11'd64, 11'd32, 11'd96, 11'd32, 11'd96
    };

endpackage

// File: rtl/diamond_bitmap.sv
// Purpose: 32x32 diamond sprite ROM, 12-bit RGB per texel, TRANSPARENT outside the gem.
// Latency: combinational read.
// Backpressure: none.
import digger_pkg::*;

module diamond_bitmap (
    input  logic [4:0]  offsetX,
    input  logic [4:0]  offsetY,
    output logic [11:0] RGB
);

    logic [3:0] dist_x;
    logic [3:0] dist_y;
    logic [4:0] dist_sum;

    // Texel is inside the gem when its Manhattan distance from the cell centre is under 16.
    always_comb begin
        dist_x   = offsetX[4] ? offsetX[3:0] : ~offsetX[3:0];
        dist_y   = offsetY[4] ? offsetY[3:0] : ~offsetY[3:0];
        dist_sum = {1'b0, dist_x} + {1'b0, dist_y};
        RGB      = dist_sum[4] ? TRANSPARENT : {4'hC, offsetX[4:1], offsetY[4:1]};
    end

endmodule

// File: rtl/diamond_block.sv
// Purpose: draws collectable diamonds, removes them on player collision, tracks remaining count.
// Latency: one cycle from pixelX/pixelY to diamond_dr/diamond_RGB; eat pulse one cycle after collision.
// Backpressure: none; streams one pixel per clock.
import digger_pkg::*;

module diamond_block #(
    parameter int          NUM_DIAMONDS     = 8,
    parameter logic [10:0] board_position_X = 11'd32,
    parameter logic [10:0] board_position_Y = 11'd160
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        collision,
    output logic        diamond_dr,
    output logic [11:0] diamond_RGB,
    output logic        player_eat_diamond,
    output logic [3:0]  diamonds_left,
    output logic        all_collected
);

    localparam logic [MAX_DIAMONDS-1:0] ALIVE_INIT =
        {MAX_DIAMONDS{1'b1}} >> (MAX_DIAMONDS - NUM_DIAMONDS);
    localparam logic [MAX_DIAMONDS-1:0] ONE_HOT0 = {{(MAX_DIAMONDS-1){1'b0}}, 1'b1};
    localparam logic [10:0] CELL = 11'(DIAMOND_SIZE);

    logic [MAX_DIAMONDS-1:0] alive_q, alive_d;
    logic                    diamond_dr_q, diamond_dr_d;
    logic [11:0]             diamond_rgb_q, diamond_rgb_d;
    logic                    eat_q, eat_d;
    logic [3:0]              diamonds_left_q, diamonds_left_d;
    logic                    all_collected_q, all_collected_d;
    logic [2:0]              hit_index_q, hit_index_d;
    logic [5:0]              sparkle_q, sparkle_d;

    logic                    sel_hit;
    logic [2:0]              sel_idx;
    logic [4:0]              off_x, off_y;
    logic [11:0]             bmp_rgb;

    diamond_bitmap u_bitmap (
        .offsetX (off_x),
        .offsetY (off_y),
        .RGB     (bmp_rgb)
    );

    // Collision retires the diamond drawn last cycle; it is masked out of this cycle's hit search
    // so a collected diamond stops drawing immediately.
    always_comb begin
        eat_d   = collision && diamond_dr_q && alive_q[hit_index_q];
        alive_d = eat_d ? (alive_q & ~(ONE_HOT0 << hit_index_q)) : alive_q;
        sel_hit = 1'b0;
        sel_idx = 3'd0;
        off_x   = 5'd0;
        off_y   = 5'd0;
        // Descending scan so the lowest index overrides on overlapping cells.
        for (int i = MAX_DIAMONDS - 1; i >= 0; i--) begin
            if (i < NUM_DIAMONDS && alive_d[i]
                && pixelX >= board_position_X + DIAMOND_POS_X[i]
                && pixelX <  board_position_X + DIAMOND_POS_X[i] + CELL
                && pixelY >= board_position_Y + DIAMOND_POS_Y[i]
                && pixelY <  board_position_Y + DIAMOND_POS_Y[i] + CELL) begin
                sel_hit = 1'b1;
                sel_idx = 3'(i);
                off_x   = 5'(pixelX - board_position_X - DIAMOND_POS_X[i]);
                off_y   = 5'(pixelY - board_position_Y - DIAMOND_POS_Y[i]);
            end
        end
    end

    // Next-state for draw outputs, counters and status.
    always_comb begin
        diamond_dr_d    = sel_hit && (bmp_rgb != TRANSPARENT);
        diamond_rgb_d   = 12'h000;
        if (diamond_dr_d) begin
            diamond_rgb_d = (sparkle_q >= SPARKLE_START) ? (bmp_rgb ^ SPARKLE_MASK) : bmp_rgb;
        end
        hit_index_d     = diamond_dr_d ? sel_idx : hit_index_q;
        diamonds_left_d = (eat_d && diamonds_left_q != 4'd0) ? diamonds_left_q - 4'd1
                                                             : diamonds_left_q;
        all_collected_d = (diamonds_left_q == 4'd0);
        sparkle_d       = startOfFrame ? sparkle_q + 6'd1 : sparkle_q;
    end

    // State registers; reset restores every diamond and drops any pulse in flight.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            alive_q         <= ALIVE_INIT;
            diamond_dr_q    <= 1'b0;
            diamond_rgb_q   <= 12'h000;
            eat_q           <= 1'b0;
            diamonds_left_q <= 4'(NUM_DIAMONDS);
            all_collected_q <= 1'b0;
            hit_index_q     <= 3'd0;
            sparkle_q       <= 6'd0;
        end else begin
            alive_q         <= alive_d;
            diamond_dr_q    <= diamond_dr_d;
            diamond_rgb_q   <= diamond_rgb_d;
            eat_q           <= eat_d;
            diamonds_left_q <= diamonds_left_d;
            all_collected_q <= all_collected_d;
            hit_index_q     <= hit_index_d;
            sparkle_q       <= sparkle_d;
        end
    end

    assign diamond_dr         = diamond_dr_q;
    assign diamond_RGB        = diamond_rgb_q;
    assign player_eat_diamond = eat_q;
    assign diamonds_left      = diamonds_left_q;
    assign all_collected      = all_collected_q;

endmodule

// File: tb/tb_diamond_block.sv
// Purpose: self-checking bench for diamond_block against a geometric reference model.
// Latency: expects outputs one clock after each pixel is presented.
// Backpressure: none.
import digger_pkg::*;

module tb_diamond_block;

    localparam int N  = 8;
    localparam int BX = 32;
    localparam int BY = 160;

    logic        clk = 1'b0;
    logic        resetN;
    logic        startOfFrame;
    logic [10:0] pixelX, pixelY;
    logic        collision;
    logic        diamond_dr;
    logic [11:0] diamond_RGB;
    logic        player_eat_diamond;
    logic [3:0]  diamonds_left;
    logic        all_collected;

    diamond_block #(
        .NUM_DIAMONDS     (8),
        .board_position_X (11'd32),
        .board_position_Y (11'd160)
    ) dut (
        .clk                (clk),
        .resetN             (resetN),
        .startOfFrame       (startOfFrame),
        .pixelX             (pixelX),
        .pixelY             (pixelY),
        .collision          (collision),
        .diamond_dr         (diamond_dr),
        .diamond_RGB        (diamond_RGB),
        .player_eat_diamond (player_eat_diamond),
        .diamonds_left      (diamonds_left),
        .all_collected      (all_collected)
    );

    always #20 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit m_alive [N];
    int m_left;
    int m_spark;
    bit m_prev_dr;
    int m_prev_idx;
    int pulse_cnt;
    int drawn_cnt [N];

    // Expected outputs after the most recent step
    bit e_dr;
    int e_rgb;
    int e_idx;
    bit e_eat;
    int e_left;
    bit e_all;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Geometric cell containing a pixel, ignoring alive state; -1 if none.
    function automatic int cell_of(input int px, input int py);
        for (int i = 0; i < N; i++) begin
            int cx = BX + int'(DIAMOND_POS_X[i]);
            int cy = BY + int'(DIAMOND_POS_Y[i]);
            if (px >= cx && px < cx + 32 && py >= cy && py < cy + 32) return i;
        end
        return -1;
    endfunction

    function automatic int center_x(input int i);
        return BX + int'(DIAMOND_POS_X[i]) + 16;
    endfunction

    function automatic int center_y(input int i);
        return BY + int'(DIAMOND_POS_Y[i]) + 16;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_alive[i] = 1'b1;
        m_left     = N;
        m_spark    = 0;
        m_prev_dr  = 1'b0;
        m_prev_idx = 0;
    endtask

    // Expected drawing for a pixel: first alive cell containing it, gem = diamond-shaped mask.
    task automatic model_pixel(input int px, input int py, output bit dr, output int rgb,
                               output int idx);
        dr  = 1'b0;
        rgb = 0;
        idx = -1;
        for (int i = 0; i < N; i++) begin
            int cx = BX + int'(DIAMOND_POS_X[i]);
            int cy = BY + int'(DIAMOND_POS_Y[i]);
            if (idx < 0 && m_alive[i] && px >= cx && px < cx + 32 && py >= cy && py < cy + 32) begin
                int ox = px - cx;
                int oy = py - cy;
                idx = i;
                if (iabs(2 * ox - 31) + iabs(2 * oy - 31) <= 32) begin
                    dr  = 1'b1;
                    rgb = 'hC00 + (ox / 2) * 16 + (oy / 2);
                    if (m_spark >= 48) rgb = rgb ^ 'h0F0;
                end
            end
        end
    endtask

    // Present one pixel for one clock, advance the model, leave time at edge + 1.
    task automatic step(input int px, input int py, input bit col, input bit sof);
        bit eat;
        int left_before;
        pixelX       = 11'(px);
        pixelY       = 11'(py);
        collision    = col;
        startOfFrame = sof;
        left_before  = m_left;
        eat = col && m_prev_dr && m_alive[m_prev_idx];
        if (eat) begin
            m_alive[m_prev_idx] = 1'b0;
            if (m_left > 0) m_left--;
        end
        model_pixel(px, py, e_dr, e_rgb, e_idx);
        e_eat  = eat;
        e_left = m_left;
        e_all  = (left_before == 0);
        if (sof) m_spark = (m_spark + 1) % 64;
        @(posedge clk);
        #1;
        if (player_eat_diamond) pulse_cnt++;
        m_prev_dr = e_dr;
        if (e_dr) m_prev_idx = e_idx;
        collision    = 1'b0;
        startOfFrame = 1'b0;
    endtask

    task automatic apply_reset();
        collision    = 1'b0;
        startOfFrame = 1'b0;
        pixelX       = 11'd0;
        pixelY       = 11'd0;
        resetN       = 1'b0;
        #10;
        @(posedge clk);
        #1;
        resetN = 1'b1;
        model_reset();
    endtask

    // Sampled board scan with per-pixel checks; optional random collisions.
    task automatic scan_frame(input string tag, input bit rand_col);
        for (int i = 0; i < N; i++) drawn_cnt[i] = 0;
        step(0, 0, 1'b0, 1'b1);
        for (int y = 140; y <= 300; y += 4) begin
            for (int x = 16; x <= 528; x += 4) begin
                step(x, y, rand_col && ($urandom_range(0, 2) == 0), 1'b0);
                checks++;
                if (diamond_dr !== e_dr) begin
                    failures++;
                    $display("FAIL %s dr at (%0d,%0d): got %b expected %b", tag, x, y, diamond_dr, e_dr);
                end
                checks++;
                if (diamond_RGB !== 12'(e_rgb)) begin
                    failures++;
                    $display("FAIL %s rgb at (%0d,%0d): got %h expected %h", tag, x, y, diamond_RGB, 12'(e_rgb));
                end
                checks++;
                if (player_eat_diamond !== e_eat) begin
                    failures++;
                    $display("FAIL %s eat at (%0d,%0d): got %b expected %b", tag, x, y, player_eat_diamond, e_eat);
                end
                if (diamond_dr === 1'b1 && cell_of(x, y) >= 0) drawn_cnt[cell_of(x, y)]++;
            end
        end
    endtask

    task automatic test_reset();
        pixelX = 11'd0; pixelY = 11'd0; collision = 1'b0; startOfFrame = 1'b0;
        resetN = 1'b1;
        #1;
        resetN = 1'b0;
        #5;
        checks++;
        if ({diamond_dr, diamond_RGB, player_eat_diamond, diamonds_left, all_collected} !==
            {1'b0, 12'h000, 1'b0, 4'd8, 1'b0}) begin
            failures++;
            $display("FAIL reset outputs: got dr=%b rgb=%h eat=%b left=%0d all=%b expected 0 000 0 8 0",
                     diamond_dr, diamond_RGB, player_eat_diamond, diamonds_left, all_collected);
        end
        @(posedge clk);
        #1;
        resetN = 1'b1;
        model_reset();
    endtask

    task automatic test_full_frame();
        scan_frame("full_frame", 1'b0);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (drawn_cnt[i] == 0) begin
                failures++;
                $display("FAIL full_frame cell %0d drawn count: got 0 expected nonzero", i);
            end
        end
        checks++;
        if (diamonds_left !== 4'd8 || all_collected !== 1'b0) begin
            failures++;
            $display("FAIL full_frame status: got left=%0d all=%b expected 8 0", diamonds_left, all_collected);
        end
    endtask

    task automatic test_collision_hold();
        int p0;
        step(center_x(3), center_y(3), 1'b0, 1'b0);
        checks++;
        if (diamond_dr !== 1'b1) begin
            failures++;
            $display("FAIL hold pre-draw diamond 3: got %b expected 1", diamond_dr);
        end
        p0 = pulse_cnt;
        for (int k = 0; k < 10; k++) begin
            step(center_x(3), center_y(3), 1'b1, 1'b0);
            checks++;
            if (player_eat_diamond !== e_eat || diamond_dr !== e_dr) begin
                failures++;
                $display("FAIL hold cycle %0d: got eat=%b dr=%b expected eat=%b dr=%b",
                         k, player_eat_diamond, diamond_dr, e_eat, e_dr);
            end
        end
        checks++;
        if (pulse_cnt - p0 !== 1) begin
            failures++;
            $display("FAIL hold pulse count: got %0d expected 1", pulse_cnt - p0);
        end
        checks++;
        if (diamonds_left !== 4'd7) begin
            failures++;
            $display("FAIL hold diamonds_left: got %0d expected 7", diamonds_left);
        end
        scan_frame("after_hold", 1'b0);
        checks++;
        if (drawn_cnt[3] != 0) begin
            failures++;
            $display("FAIL after_hold diamond 3 drawn: got %0d pixels expected 0", drawn_cnt[3]);
        end
    endtask

    task automatic test_no_draw_collision();
        int p0 = pulse_cnt;
        step(0, 0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) step(0, 0, 1'b1, 1'b0);
        // Transparent corner of a live cell: inside the cell but not drawn.
        for (int k = 0; k < 5; k++) step(BX, BY, 1'b1, 1'b0);
        checks++;
        if (pulse_cnt - p0 !== 0) begin
            failures++;
            $display("FAIL no_draw pulses: got %0d expected 0", pulse_cnt - p0);
        end
        checks++;
        if (diamonds_left !== 4'd7) begin
            failures++;
            $display("FAIL no_draw diamonds_left: got %0d expected 7", diamonds_left);
        end
    endtask

    task automatic test_collect_all();
        int p0;
        apply_reset();
        p0 = pulse_cnt;
        for (int i = 0; i < N; i++) begin
            step(center_x(i), center_y(i), 1'b0, 1'b0);
            step(center_x(i), center_y(i), 1'b1, 1'b0);
            checks++;
            if (player_eat_diamond !== 1'b1 || diamonds_left !== 4'(N - 1 - i)) begin
                failures++;
                $display("FAIL collect %0d: got eat=%b left=%0d expected 1 %0d",
                         i, player_eat_diamond, diamonds_left, N - 1 - i);
            end
            checks++;
            if (all_collected !== 1'b0) begin
                failures++;
                $display("FAIL collect %0d all_collected early: got %b expected 0", i, all_collected);
            end
        end
        step(0, 0, 1'b0, 1'b0);
        checks++;
        if (all_collected !== 1'b1 || player_eat_diamond !== 1'b0) begin
            failures++;
            $display("FAIL collect all_collected: got all=%b eat=%b expected 1 0", all_collected, player_eat_diamond);
        end
        checks++;
        if (pulse_cnt - p0 !== 8) begin
            failures++;
            $display("FAIL collect pulse count: got %0d expected 8", pulse_cnt - p0);
        end
        p0 = pulse_cnt;
        scan_frame("collected_scan", 1'b1);
        checks++;
        if (pulse_cnt - p0 !== 0 || diamonds_left !== 4'd0 || all_collected !== 1'b1) begin
            failures++;
            $display("FAIL collected further: got pulses=%0d left=%0d all=%b expected 0 0 1",
                     pulse_cnt - p0, diamonds_left, all_collected);
        end
    endtask

    task automatic test_reset_mid_pulse();
        apply_reset();
        step(center_x(0), center_y(0), 1'b0, 1'b0);
        step(center_x(0), center_y(0), 1'b1, 1'b0);
        checks++;
        if (player_eat_diamond !== 1'b1) begin
            failures++;
            $display("FAIL mid_pulse setup eat: got %b expected 1", player_eat_diamond);
        end
        resetN = 1'b0;
        #2;
        checks++;
        if (player_eat_diamond !== 1'b0 || diamonds_left !== 4'd8 || diamond_dr !== 1'b0) begin
            failures++;
            $display("FAIL mid_pulse reset: got eat=%b left=%0d dr=%b expected 0 8 0",
                     player_eat_diamond, diamonds_left, diamond_dr);
        end
        @(posedge clk);
        #1;
        resetN = 1'b1;
        model_reset();
        scan_frame("mid_pulse_scan", 1'b0);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (drawn_cnt[i] == 0) begin
                failures++;
                $display("FAIL mid_pulse cell %0d drawn: got 0 expected nonzero", i);
            end
        end
    endtask

    task automatic test_sparkle();
        int active = 0;
        apply_reset();
        for (int k = 1; k <= 64; k++) begin
            step(0, 0, 1'b0, 1'b1);
            step(center_x(5), center_y(5), 1'b0, 1'b0);
            checks++;
            if (diamond_dr !== 1'b1 ||
                diamond_RGB !== (((k % 64) >= 48) ? (12'hC88 ^ 12'h0F0) : 12'hC88)) begin
                failures++;
                $display("FAIL sparkle frame %0d: got dr=%b rgb=%h expected 1 %h", k, diamond_dr, diamond_RGB,
                         ((k % 64) >= 48) ? (12'hC88 ^ 12'h0F0) : 12'hC88);
            end
            if (diamond_RGB === (12'hC88 ^ 12'h0F0)) active++;
        end
        checks++;
        if (active != 16) begin
            failures++;
            $display("FAIL sparkle active frames: got %0d expected 16", active);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int k = 0; k < 2500; k++) begin
            int px, py;
            if ($urandom_range(0, 1) == 0) begin
                int c = $urandom_range(0, N - 1);
                px = BX + int'(DIAMOND_POS_X[c]) + $urandom_range(0, 31);
                py = BY + int'(DIAMOND_POS_Y[c]) + $urandom_range(0, 31);
            end else begin
                px = $urandom_range(0, 639);
                py = $urandom_range(0, 479);
            end
            step(px, py, $urandom_range(0, 5) == 0, $urandom_range(0, 40) == 0);
            checks++;
            if (diamond_dr !== e_dr || diamond_RGB !== 12'(e_rgb) || player_eat_diamond !== e_eat ||
                diamonds_left !== 4'(e_left) || all_collected !== e_all) begin
                failures++;
                $display("FAIL random %0d (%0d,%0d): got dr=%b rgb=%h eat=%b left=%0d all=%b expected %b %h %b %0d %b",
                         k, px, py, diamond_dr, diamond_RGB, player_eat_diamond, diamonds_left, all_collected,
                         e_dr, 12'(e_rgb), e_eat, e_left, e_all);
            end
        end
    endtask

    initial begin
        pulse_cnt = 0;
        model_reset();
        test_reset();
        test_full_frame();
        test_collision_hold();
        test_no_draw_collision();
        test_collect_all();
        test_reset_mid_pulse();
        test_sparkle();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
